// File: rtl/uart_debug_ifc.sv
// uart_debug_ifc: UART (8N1) debug loader. Parses 'W' AH AL DH DL and
// 'N' DH DL packets into single-cycle writes on the debug write bus.
// Optional ack transmitter (0x06 per write) is built when the macro
// UART_DEBUG_ACK_EN is defined; otherwise uart_tx_o is tied high.
module uart_debug_ifc #(
    parameter int unsigned CLKDIV       = 104,
    parameter int unsigned TIMEOUT_BITS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        sys_wr_o,
    output logic [15:0] sys_waddr_o,
    output logic [15:0] sys_wdata_o,
    output logic        frame_err_o
);

    localparam logic [15:0] HALF_M1   = 16'(CLKDIV / 2 - 1);
    localparam logic [15:0] BIT_M1    = 16'(CLKDIV - 1);
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKDIV;
    localparam int unsigned TOW       = $clog2(TO_CYCLES + 1);
    localparam logic [TOW-1:0] TO_M1  = TOW'(TO_CYCLES - 1);
    localparam logic [TOW-1:0] TO_ONE = TOW'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_CMD, P_AH, P_AL, P_DH, P_DL} p_state_t;

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    rx_state_t       rx_state;
    logic [15:0]     rx_cnt;
    logic [2:0]      rx_bits;
    logic [7:0]      rx_shift;
    logic            stop_tick;
    logic            rx_done;
    logic            rx_ferr;

    p_state_t        p_state;
    logic [15:0]     addr;
    logic [7:0]      data_hi;
    logic [15:0]     last_addr;
    logic [TOW-1:0]  to_cnt;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive FSM: start-bit qualification at half a bit, then mid-bit sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bits  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= 16'd0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt <= 16'd0;
                        if (!rx_sync) begin
                            rx_state <= RX_DATA;
                            rx_bits  <= 3'd0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_M1) begin
                        rx_cnt   <= 16'd0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bits == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bits <= rx_bits + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_M1) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                    rx_cnt   <= 16'd0;
                end
            endcase
        end
    end

    // Stop-bit sample decodes into byte-complete or framing-error this cycle.
    always_comb begin
        stop_tick = 1'b0;
        rx_done   = 1'b0;
        rx_ferr   = 1'b0;
        if ((rx_state == RX_STOP) && (rx_cnt == BIT_M1)) begin
            stop_tick = 1'b1;
        end else begin
            stop_tick = 1'b0;
        end
        if (stop_tick) begin
            rx_done = rx_sync;
            rx_ferr = !rx_sync;
        end else begin
            rx_done = 1'b0;
            rx_ferr = 1'b0;
        end
    end

    // Packet parser with inactivity timeout; issues the registered write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_state     <= P_CMD;
            addr        <= 16'h0000;
            data_hi     <= 8'h00;
            last_addr   <= 16'hFFFF;
            to_cnt      <= '0;
            sys_wr_o    <= 1'b0;
            sys_waddr_o <= 16'h0000;
            sys_wdata_o <= 16'h0000;
            frame_err_o <= 1'b0;
        end else begin
            sys_wr_o    <= 1'b0;
            frame_err_o <= rx_ferr;
            if (rx_ferr) begin
                p_state <= P_CMD;
                to_cnt  <= '0;
            end else if (rx_done) begin
                // A completed byte always beats a coincident timeout.
                to_cnt <= '0;
                case (p_state)
                    P_CMD: begin
                        if (rx_shift == 8'h57) begin
                            p_state <= P_AH;
                        end else if (rx_shift == 8'h4E) begin
                            addr    <= last_addr + 16'd1;
                            p_state <= P_DH;
                        end else begin
                            p_state <= P_CMD;
                        end
                    end
                    P_AH: begin
                        addr[15:8] <= rx_shift;
                        p_state    <= P_AL;
                    end
                    P_AL: begin
                        addr[7:0] <= rx_shift;
                        p_state   <= P_DH;
                    end
                    P_DH: begin
                        data_hi <= rx_shift;
                        p_state <= P_DL;
                    end
                    P_DL: begin
                        sys_wr_o    <= 1'b1;
                        sys_waddr_o <= addr;
                        sys_wdata_o <= {data_hi, rx_shift};
                        last_addr   <= addr;
                        p_state     <= P_CMD;
                    end
                    default: begin
                        p_state <= P_CMD;
                    end
                endcase
            end else if (p_state != P_CMD) begin
                if (to_cnt == TO_M1) begin
                    p_state <= P_CMD;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_ONE;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

`ifdef UART_DEBUG_ACK_EN
    logic        tx_busy;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bits;
    logic [8:0]  tx_shift;

    // Ack transmitter: one 0x06 frame per write, requests while busy are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy   <= 1'b0;
            tx_cnt    <= 16'd0;
            tx_bits   <= 4'd0;
            tx_shift  <= 9'h1FF;
            uart_tx_o <= 1'b1;
        end else if (!tx_busy) begin
            if (sys_wr_o) begin
                tx_busy   <= 1'b1;
                tx_cnt    <= 16'd0;
                tx_bits   <= 4'd0;
                tx_shift  <= {1'b1, 8'h06};
                uart_tx_o <= 1'b0;
            end
        end else if (tx_cnt == BIT_M1) begin
            tx_cnt <= 16'd0;
            if (tx_bits == 4'd9) begin
                tx_busy   <= 1'b0;
                uart_tx_o <= 1'b1;
            end else begin
                uart_tx_o <= tx_shift[0];
                tx_shift  <= {1'b1, tx_shift[8:1]};
                tx_bits   <= tx_bits + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end
`else
    assign uart_tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_debug_ifc.sv
// Self-checking bench for uart_debug_ifc at CLKDIV=16 with directed
// scenarios plus randomized packet streams checked against a packet model.
module tb_uart_debug_ifc;

    localparam int CLKDIV = 16;
    localparam int TOB    = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        uart_tx;
    logic        sys_wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        frame_err;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        int          c;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ferr_cnt = 0;
    bit         tx_low_seen = 1'b0;
    bit         tx_log [0:131071];
    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] seq[$];
    logic [15:0] m_last;

    always #5 clk = ~clk;

    uart_debug_ifc #(.CLKDIV(CLKDIV), .TIMEOUT_BITS(TOB)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx_i  (uart_rx),
        .uart_tx_o  (uart_tx),
        .sys_wr_o   (sys_wr),
        .sys_waddr_o(waddr),
        .sys_wdata_o(wdata),
        .frame_err_o(frame_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (sys_wr === 1'b1) obs_q.push_back('{waddr, wdata, cyc});
            if (frame_err === 1'b1) ferr_cnt++;
            if (cyc < 131072) tx_log[cyc] = uart_tx;
            if (uart_tx !== 1'b1) tx_low_seen = 1'b1;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        logic [9:0] fr;
        fr = {~bad_stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (CLKDIV) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_seq(input int max_gap);
        for (int i = 0; i < seq.size(); i++) begin
            send_byte(seq[i], 1'b0);
            if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        uart_rx = 1'b1;
        idle_cycles(3);
        reset  = 1'b0;
        m_last = 16'hFFFF;
        idle_cycles(2);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
    endtask

    // Packet-level reference: scan the byte stream for complete W/N packets.
    task automatic model_run();
        int i;
        logic [15:0] a;
        i = 0;
        while (i < seq.size()) begin
            if (seq[i] == 8'h57 && i + 4 < seq.size()) begin
                a = {seq[i+1], seq[i+2]};
                exp_q.push_back('{a, {seq[i+3], seq[i+4]}, 0});
                m_last = a;
                i += 5;
            end else if (seq[i] == 8'h4E && i + 2 < seq.size()) begin
                a = m_last + 16'd1;
                exp_q.push_back('{a, {seq[i+1], seq[i+2]}, 0});
                m_last = a;
                i += 3;
            end else begin
                i += 1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (sys_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", sys_wr); end
        if (waddr !== 16'h0000) begin errors++; $display("FAIL reset_waddr got %h want 0000", waddr); end
        if (wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h want 0000", wdata); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    endtask

    task automatic test_single();
        logic [9:0] ack;
        int         wc;
        bit         ok;
        do_reset();
        clear_obs();
        seq = '{8'h57, 8'h00, 8'h12, 8'hBE, 8'hEF};
        send_seq(0);
        idle_cycles(15 * CLKDIV);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL single_count got %0d want 1", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].a !== 16'h0012) begin errors++; $display("FAIL single_addr got %h want 0012", obs_q[0].a); end
            if (obs_q[0].d !== 16'hBEEF) begin errors++; $display("FAIL single_data got %h want BEEF", obs_q[0].d); end
`ifdef UART_DEBUG_ACK_EN
            wc  = obs_q[0].c;
            ack = {1'b1, 8'h06, 1'b0};
            for (int b = 0; b < 10; b++) begin
                ok = 1'b1;
                for (int k = 0; k < CLKDIV; k++)
                    if (tx_log[wc + 1 + b * CLKDIV + k] !== ack[b]) ok = 1'b0;
                checks++;
                if (!ok) begin errors++; $display("FAIL ack_bit%0d got wrong level want %b", b, ack[b]); end
            end
`endif
        end
        checks++;
        if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_wrap();
        clear_obs();
        seq = '{8'h57, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h4E, 8'h00, 8'h02};
        send_seq(0);
        idle_cycles(2 * CLKDIV);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL wrap_count got %0d want 2", obs_q.size());
        end else begin
            checks += 4;
            if (obs_q[0].a !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0 got %h want FFFF", obs_q[0].a); end
            if (obs_q[0].d !== 16'h0001) begin errors++; $display("FAIL wrap_data0 got %h want 0001", obs_q[0].d); end
            if (obs_q[1].a !== 16'h0000) begin errors++; $display("FAIL wrap_addr1 got %h want 0000", obs_q[1].a); end
            if (obs_q[1].d !== 16'h0002) begin errors++; $display("FAIL wrap_data1 got %h want 0002", obs_q[1].d); end
        end
    endtask

    task automatic test_frame_err();
        clear_obs();
        send_byte(8'h57, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b1);
        idle_cycles(CLKDIV);
        seq = '{8'h57, 8'h80, 8'h01, 8'h00, 8'h41};
        send_seq(0);
        idle_cycles(2 * CLKDIV);
        checks += 2;
        if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt); end
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL ferr_wr_count got %0d want 1", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].a !== 16'h8001) begin errors++; $display("FAIL ferr_addr got %h want 8001", obs_q[0].a); end
            if (obs_q[0].d !== 16'h0041) begin errors++; $display("FAIL ferr_data got %h want 0041", obs_q[0].d); end
        end
    endtask

    task automatic test_timeout();
        clear_obs();
        seq = '{8'h57, 8'h00, 8'h05};
        send_seq(0);
        idle_cycles(300 * CLKDIV);
        seq = '{8'h12, 8'h34, 8'h57, 8'h00, 8'h06, 8'h00, 8'h07};
        send_seq(0);
        idle_cycles(2 * CLKDIV);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL timeout_count got %0d want 1", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].a !== 16'h0006) begin errors++; $display("FAIL timeout_addr got %h want 0006", obs_q[0].a); end
            if (obs_q[0].d !== 16'h0007) begin errors++; $display("FAIL timeout_data got %h want 0007", obs_q[0].d); end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        seq = '{8'h57, 8'hF0, 8'h00, 8'h00};
        send_seq(0);
        uart_rx = 1'b0;
        idle_cycles(CLKDIV);
        uart_rx = 1'b1;
        idle_cycles(4 * CLKDIV);
        reset   = 1'b1;
        idle_cycles(3);
        reset   = 1'b0;
        m_last  = 16'hFFFF;
        idle_cycles(6 * CLKDIV);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_nowrite got %0d want 0", obs_q.size()); end
        clear_obs();
        seq = '{8'h57, 8'hF0, 8'h00, 8'h00, 8'h01};
        send_seq(0);
        idle_cycles(2 * CLKDIV);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL rstmid_count got %0d want 1", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].a !== 16'hF000) begin errors++; $display("FAIL rstmid_addr got %h want F000", obs_q[0].a); end
            if (obs_q[0].d !== 16'h0001) begin errors++; $display("FAIL rstmid_data got %h want 0001", obs_q[0].d); end
        end
    endtask

    task automatic test_random();
        logic [7:0] j;
        do_reset();
        clear_obs();
        seq.delete();
        for (int p = 0; p < 14; p++) begin
            if ($urandom_range(0, 2) == 0) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'h57 || j == 8'h4E) j = 8'h00;
                seq.push_back(j);
            end
            if ($urandom_range(0, 1) == 0) begin
                seq.push_back(8'h4E);
            end else begin
                seq.push_back(8'h57);
                seq.push_back(8'($urandom_range(0, 255)));
                seq.push_back(8'($urandom_range(0, 255)));
            end
            seq.push_back(8'($urandom_range(0, 255)));
            seq.push_back(8'($urandom_range(0, 255)));
        end
        send_seq(20);
        idle_cycles(2 * CLKDIV);
        model_run();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d) begin
                    errors++;
                    $display("FAIL rand_wr%0d got %h/%h want %h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        checks++;
        if (ferr_cnt != 0) begin errors++; $display("FAIL rand_ferr got %0d want 0", ferr_cnt); end
    endtask

    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        m_last  = 16'hFFFF;
        test_reset();
        test_single();
        test_wrap();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        test_random();
`ifndef UART_DEBUG_ACK_EN
        checks++;
        if (tx_low_seen) begin errors++; $display("FAIL tx_idle got low want constant 1"); end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
